// File: rtl/ahb_lite_fetch_arbiter.sv
// Two-master AHB-Lite arbiter sharing one slave port between the I-cache (M0)
// and the load/store port (M1), with bounded-hold preemption and transfer replay.
module ahb_lite_fetch_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic [2:0]  m0_hburst,
    input  logic [2:0]  m0_hsize,
    input  logic        m0_hwrite,
    input  logic [31:0] m0_hwdata,
    output logic [31:0] m0_hrdata,
    output logic        m0_hready,
    output logic        m0_hresp,

    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic [2:0]  m1_hburst,
    input  logic [2:0]  m1_hsize,
    input  logic        m1_hwrite,
    input  logic [31:0] m1_hwdata,
    output logic [31:0] m1_hrdata,
    output logic        m1_hready,
    output logic        m1_hresp,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TRANS_W = 2;
    localparam int unsigned BURST_W = 3;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned NUM_M   = 2;
    localparam int unsigned CNT_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_LIMIT  = CNT_W'(HOLD_MAX);
    localparam bit                 PREEMPT_EN = (HOLD_MAX != 0);

    localparam logic [TRANS_W-1:0] TR_IDLE   = 2'b00;
    localparam logic [TRANS_W-1:0] TR_BUSY   = 2'b01;
    localparam logic [TRANS_W-1:0] TR_NONSEQ = 2'b10;
    localparam logic [TRANS_W-1:0] TR_SEQ    = 2'b11;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] burst;
        logic [SIZE_W-1:0]  size;
        logic               write;
    } addr_phase_t;

    // Per-master views of the live request
    addr_phase_t          live_ap    [NUM_M];
    logic [TRANS_W-1:0]   live_trans [NUM_M];
    logic [DATA_W-1:0]    live_wdata [NUM_M];

    // Arbitration state
    logic                 owner_q,    owner_d;
    logic                 downer_q,   downer_d;
    logic                 dvalid_q,   dvalid_d;
    logic                 restart_q,  restart_d;
    logic [NUM_M-1:0]     pend_valid_q, pend_valid_d;
    addr_phase_t          pend_q     [NUM_M];
    addr_phase_t          pend_d     [NUM_M];
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;

    // Decoded requests and bus selection
    logic [NUM_M-1:0]     req_c;
    logic [NUM_M-1:0]     want_c;
    logic                 other_c;
    logic                 want_owner_c;
    logic                 want_other_c;
    logic                 preempt_c;
    addr_phase_t          bus_ap_c;
    logic [TRANS_W-1:0]   bus_trans_c;
    logic                 replay_c;
    logic                 issued_c;
    logic [NUM_M-1:0]     hready_c;
    logic [NUM_M-1:0]     hresp_c;

    assign live_ap[0]    = '{addr: m0_haddr, burst: m0_hburst, size: m0_hsize, write: m0_hwrite};
    assign live_ap[1]    = '{addr: m1_haddr, burst: m1_hburst, size: m1_hsize, write: m1_hwrite};
    assign live_trans[0] = m0_htrans;
    assign live_trans[1] = m1_htrans;
    assign live_wdata[0] = m0_hwdata;
    assign live_wdata[1] = m1_hwdata;

    // Request decode and preemption condition
    always_comb begin : req_decode
        req_c        = {m1_htrans[1], m0_htrans[1]};
        want_c       = req_c | pend_valid_q;
        other_c      = ~owner_q;
        want_owner_c = want_c[owner_q];
        want_other_c = want_c[other_c];
        preempt_c    = PREEMPT_EN && want_owner_c && want_other_c &&
                       (hold_cnt_q >= CNT_LIMIT) && !pend_valid_q[owner_q];
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin : state_reg
        if (!HRESETn) begin
            owner_q      <= 1'b0;
            downer_q     <= 1'b0;
            dvalid_q     <= 1'b0;
            restart_q    <= 1'b1;
            pend_valid_q <= '0;
            pend_q[0]    <= '0;
            pend_q[1]    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            owner_q      <= owner_d;
            downer_q     <= downer_d;
            dvalid_q     <= dvalid_d;
            restart_q    <= restart_d;
            pend_valid_q <= pend_valid_d;
            pend_q[0]    <= pend_d[0];
            pend_q[1]    <= pend_d[1];
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    // Next-state: everything advances only on an accepted bus cycle
    always_comb begin : next_state
        owner_d      = owner_q;
        downer_d     = downer_q;
        dvalid_d     = dvalid_q;
        restart_d    = restart_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        hold_cnt_d   = hold_cnt_q;

        if (HREADY) begin
            downer_d = owner_q;
            dvalid_d = issued_c;

            if (issued_c) begin
                restart_d = 1'b0;
            end
            if (replay_c) begin
                pend_valid_d[owner_q] = 1'b0;
            end

            if (preempt_c) begin
                pend_valid_d[owner_q] = 1'b1;
                pend_d[owner_q]       = live_ap[owner_q];
                owner_d               = other_c;
                hold_cnt_d            = '0;
                restart_d             = 1'b1;
            end else if (want_other_c && !want_owner_c) begin
                owner_d    = other_c;
                hold_cnt_d = '0;
                restart_d  = 1'b1;
            end else if (issued_c && want_other_c && (hold_cnt_q != CNT_MAX)) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs: address mux plus per-master ready/response steering
    always_comb begin : outputs
        bus_ap_c    = live_ap[owner_q];
        bus_trans_c = live_trans[owner_q];
        replay_c    = 1'b0;

        if (preempt_c) begin
            bus_trans_c = TR_IDLE;
        end else if (pend_valid_q[owner_q]) begin
            bus_ap_c    = pend_q[owner_q];
            bus_trans_c = TR_NONSEQ;
            replay_c    = 1'b1;
        end else if (restart_q) begin
            // A freshly granted master must open with NONSEQ
            if (bus_trans_c == TR_SEQ) begin
                bus_trans_c = TR_NONSEQ;
            end else if (bus_trans_c == TR_BUSY) begin
                bus_trans_c = TR_IDLE;
            end
        end

        if (!HRESETn) begin
            bus_trans_c = TR_IDLE;
        end
        issued_c = bus_trans_c[1];

        hready_c = '0;
        hresp_c  = '0;
        for (int n = 0; n < NUM_M; n++) begin
            if (dvalid_q && (downer_q == 1'(n))) begin
                hready_c[n] = HREADY;
                hresp_c[n]  = HRESP;
            end else if (pend_valid_q[n]) begin
                hready_c[n] = 1'b0;
            end else if (owner_q == 1'(n)) begin
                hready_c[n] = HREADY;
            end else begin
                hready_c[n] = !req_c[n];
            end
        end
    end

    assign HADDR     = bus_ap_c.addr;
    assign HBURST    = bus_ap_c.burst;
    assign HSIZE     = bus_ap_c.size;
    assign HWRITE    = bus_ap_c.write;
    assign HTRANS    = bus_trans_c;
    assign HWDATA    = live_wdata[downer_q];

    assign m0_hready = hready_c[0];
    assign m1_hready = hready_c[1];
    assign m0_hresp  = hresp_c[0];
    assign m1_hresp  = hresp_c[1];
    assign m0_hrdata = HRDATA;
    assign m1_hrdata = HRDATA;

endmodule

// File: tb/tb_ahb_lite_fetch_arbiter.sv
// Directed bench for ahb_lite_fetch_arbiter (HOLD_MAX=4): reset, solo burst,
// idle switch, wait/error passthrough, BUSY switch and preemption with replay.
module tb_ahb_lite_fetch_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] m0_haddr, m1_haddr;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hburst, m1_hburst, m0_hsize, m1_hsize;
    logic        m0_hwrite, m1_hwrite;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE, HREADY, HRESP;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    ahb_lite_fetch_arbiter #(.HOLD_MAX(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hburst(m0_hburst),
        .m0_hsize(m0_hsize), .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata),
        .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hburst(m1_hburst),
        .m1_hsize(m1_hsize), .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata),
        .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_m0(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b);
        m0_htrans = tr;
        m0_haddr  = a;
        m0_hburst = b;
    endtask

    task automatic drive_m1(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m1_htrans = tr;
        m1_haddr  = a;
        m1_hwrite = w;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        HRESETn   = 1'b0;
        m0_hsize  = 3'b010;
        m1_hsize  = 3'b010;
        m0_hwrite = 1'b0;
        m1_hburst = 3'b000;
        m0_hwdata = 32'h0000_A0A0;
        m1_hwdata = 32'h0000_B1B1;
        HRDATA    = 32'h1234_5678;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        drive_m0(IDLE, 32'h0, 3'b000);
        drive_m1(NSEQ, 32'h9000, 1'b0);
        settle();
        settle();
        // Reset state
        chk("rst_htrans",    32'(HTRANS),    32'h0);
        chk("rst_m0_hready", 32'(m0_hready), 32'h1);
        chk("rst_m1_hready", 32'(m1_hready), 32'h0);
        chk("rst_m0_hresp",  32'(m0_hresp),  32'h0);
        chk("rst_m1_hresp",  32'(m1_hresp),  32'h0);
        chk("rst_m0_hrdata", m0_hrdata,      32'h1234_5678);
        chk("rst_m1_hrdata", m1_hrdata,      32'h1234_5678);
        chk("rst_hwdata",    HWDATA,         32'h0000_A0A0);
        tick();
        tick();
        HRESETn = 1'b1;
        drive_m1(IDLE, 32'h0, 1'b0);

        // Burst start, then reset mid-burst
        tick(); drive_m0(NSEQ, 32'h100, 3'b011); settle();
        chk("pre_nseq",  32'(HTRANS), 32'h2);
        chk("pre_addr",  HADDR,       32'h100);
        tick(); drive_m0(SEQ, 32'h104, 3'b011); settle();
        chk("pre_seq",   32'(HTRANS), 32'h3);
        tick(); drive_m0(SEQ, 32'h108, 3'b011); HRESETn = 1'b0; settle();
        chk("midrst_htrans",  32'(HTRANS),    32'h0);
        chk("midrst_haddr",   HADDR,          32'h108);
        chk("midrst_m0_hrdy", 32'(m0_hready), 32'h1);
        tick(); HRESETn = 1'b1; drive_m0(SEQ, 32'h10C, 3'b011); settle();
        chk("postrst_htrans", 32'(HTRANS), 32'h2);
        chk("postrst_haddr",  HADDR,       32'h10C);
        tick(); drive_m0(IDLE, 32'h110, 3'b011); settle();

        // Solo INCR4 burst
        for (int i = 0; i < 4; i++) begin
            tick(); drive_m0((i == 0) ? NSEQ : SEQ, 32'h100 + 32'(4 * i), 3'b011); settle();
            chk("solo_haddr",  HADDR,          32'h100 + 32'(4 * i));
            chk("solo_htrans", 32'(HTRANS),    (i == 0) ? 32'h2 : 32'h3);
            chk("solo_m1_rdy", 32'(m1_hready), 32'h1);
            chk("solo_m0_rdy", 32'(m0_hready), 32'h1);
        end
        tick(); drive_m0(IDLE, 32'h110, 3'b011); settle();

        // Grant to idle non-owner M1
        tick(); drive_m1(NSEQ, 32'h2000, 1'b0); settle();
        chk("isw_m1_stall",  32'(m1_hready), 32'h0);
        chk("isw_htrans0",   32'(HTRANS),    32'h0);
        tick(); settle();
        chk("isw_htrans1",   32'(HTRANS),    32'h2);
        chk("isw_haddr",     HADDR,          32'h2000);
        chk("isw_m1_rdy",    32'(m1_hready), 32'h1);
        tick(); drive_m1(IDLE, 32'h2004, 1'b0); HRDATA = 32'hCAFE_0001; settle();
        chk("isw_m1_hrdata", m1_hrdata,      32'hCAFE_0001);
        chk("isw_m1_dphase", 32'(m1_hready), 32'h1);
        chk("isw_m0_rdy",    32'(m0_hready), 32'h1);

        // M1 write with two wait states then a two-cycle ERROR
        tick(); drive_m1(NSEQ, 32'h3000, 1'b1); settle();
        chk("err_htrans", 32'(HTRANS), 32'h2);
        chk("err_haddr",  HADDR,       32'h3000);
        chk("err_hwrite", 32'(HWRITE), 32'h1);
        tick(); drive_m1(IDLE, 32'h3004, 1'b0); m1_hwdata = 32'hDEAD_3000;
        m0_hwdata = 32'h1111_1111; HREADY = 1'b0; settle();
        chk("ws1_hwdata", HWDATA,          32'hDEAD_3000);
        chk("ws1_m1_rdy", 32'(m1_hready),  32'h0);
        chk("ws1_m1_rsp", 32'(m1_hresp),   32'h0);
        tick(); settle();
        chk("ws2_m1_rdy", 32'(m1_hready),  32'h0);
        chk("ws2_hwdata", HWDATA,          32'hDEAD_3000);
        tick(); HRESP = 1'b1; settle();
        chk("e1_m1_rsp",  32'(m1_hresp),   32'h1);
        chk("e1_m1_rdy",  32'(m1_hready),  32'h0);
        chk("e1_m0_rsp",  32'(m0_hresp),   32'h0);
        chk("e1_hwdata",  HWDATA,          32'hDEAD_3000);
        tick(); HREADY = 1'b1; settle();
        chk("e2_m1_rsp",  32'(m1_hresp),   32'h1);
        chk("e2_m1_rdy",  32'(m1_hready),  32'h1);
        chk("e2_m0_rsp",  32'(m0_hresp),   32'h0);
        chk("e2_hwdata",  HWDATA,          32'hDEAD_3000);
        tick(); HRESP = 1'b0; settle();
        chk("e3_m1_rsp",  32'(m1_hresp),   32'h0);

        // BUSY lets M1 in without an IDLE; on regrant BUSY->IDLE, SEQ->NONSEQ
        tick(); drive_m0(NSEQ, 32'h18, 3'b001); settle();
        chk("bsw_m0_stall", 32'(m0_hready), 32'h0);
        chk("bsw_htrans0",  32'(HTRANS),    32'h0);
        tick(); settle();
        chk("bsw_nseq",     32'(HTRANS),    32'h2);
        chk("bsw_haddr18",  HADDR,          32'h18);
        tick(); drive_m0(SEQ, 32'h1C, 3'b001); settle();
        chk("bsw_seq1c",    32'(HTRANS),    32'h3);
        tick(); drive_m0(BUSY, 32'h20, 3'b001); drive_m1(NSEQ, 32'h4000, 1'b0); settle();
        chk("bsw_busy",     32'(HTRANS),    32'h1);
        chk("bsw_m1_stall", 32'(m1_hready), 32'h0);
        tick(); settle();
        chk("bsw_m1_nseq",  32'(HTRANS),    32'h2);
        chk("bsw_m1_addr",  HADDR,          32'h4000);
        chk("bsw_m1_rdy",   32'(m1_hready), 32'h1);
        chk("bsw_m0_busy",  32'(m0_hready), 32'h1);
        tick(); drive_m1(IDLE, 32'h4004, 1'b0); drive_m0(SEQ, 32'h20, 3'b001); settle();
        chk("bsw_m0_wait",  32'(m0_hready), 32'h0);
        chk("bsw_idle",     32'(HTRANS),    32'h0);
        tick(); drive_m0(BUSY, 32'h20, 3'b001); settle();
        chk("rg_busy_idle", 32'(HTRANS),    32'h0);
        chk("rg_addr",      HADDR,          32'h20);
        tick(); drive_m0(SEQ, 32'h20, 3'b001); settle();
        chk("rg_seq_nseq",  32'(HTRANS),    32'h2);
        chk("rg_addr20",    HADDR,          32'h20);
        tick(); drive_m0(SEQ, 32'h24, 3'b001); settle();
        chk("rg_seq24",     32'(HTRANS),    32'h3);
        tick(); drive_m0(IDLE, 32'h28, 3'b001); settle();

        // Preemption after 4 beats, then replay of 0x10
        tick(); drive_m0(NSEQ, 32'h0, 3'b001); drive_m1(NSEQ, 32'h8000, 1'b0); settle();
        chk("pe_nseq0",   32'(HTRANS),    32'h2);
        chk("pe_addr0",   HADDR,          32'h0);
        chk("pe_m1_wait", 32'(m1_hready), 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick(); drive_m0(SEQ, 32'(4 * i), 3'b001); settle();
            chk("pe_seq",     32'(HTRANS),    32'h3);
            chk("pe_addr",    HADDR,          32'(4 * i));
            chk("pe_m1_hold", 32'(m1_hready), 32'h0);
            chk("pe_m0_rdy",  32'(m0_hready), 32'h1);
        end
        tick(); drive_m0(SEQ, 32'h10, 3'b001); settle();
        chk("pe_idle",     32'(HTRANS),    32'h0);
        chk("pe_m0_acc",   32'(m0_hready), 32'h1);
        chk("pe_m1_wait2", 32'(m1_hready), 32'h0);
        tick(); drive_m0(SEQ, 32'h14, 3'b001); settle();
        chk("pe_m1_nseq",  32'(HTRANS),    32'h2);
        chk("pe_m1_addr",  HADDR,          32'h8000);
        chk("pe_m1_rdy",   32'(m1_hready), 32'h1);
        chk("pe_m0_ext1",  32'(m0_hready), 32'h0);
        tick(); drive_m1(IDLE, 32'h8004, 1'b0); HRDATA = 32'h8000_8000; settle();
        chk("pe_gap",      32'(HTRANS),    32'h0);
        chk("pe_m0_ext2",  32'(m0_hready), 32'h0);
        chk("pe_m1_data",  m1_hrdata,      32'h8000_8000);
        chk("pe_m1_drdy",  32'(m1_hready), 32'h1);
        tick(); settle();
        chk("rp_nseq",     32'(HTRANS),    32'h2);
        chk("rp_addr",     HADDR,          32'h10);
        chk("rp_burst",    32'(HBURST),    32'h1);
        chk("rp_m0_ext3",  32'(m0_hready), 32'h0);
        tick(); HRDATA = 32'h0000_0010; settle();
        chk("rp_seq14",    32'(HTRANS),    32'h3);
        chk("rp_addr14",   HADDR,          32'h14);
        chk("rp_m0_rdy",   32'(m0_hready), 32'h1);
        chk("rp_m0_data",  m0_hrdata,      32'h0000_0010);
        tick(); drive_m0(IDLE, 32'h18, 3'b001); settle();
        chk("rp_done_rdy", 32'(m0_hready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
